// File: rtl/rd_data_checker_if.sv
// rd_data_checker_if: user read stream, control and verdict bundle for rd_data_checker
interface rd_data_checker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  init_end;
  logic                  start;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic                  timeout;
  logic                  stray;
  logic [CNT_WIDTH-1:0]  err_cnt;
  logic [CNT_WIDTH-1:0]  word_cnt;
  logic [CNT_WIDTH-1:0]  first_err_idx;
  logic [DATA_WIDTH-1:0] first_err_data;
  modport master (
    output init_end, start, rd_en, rd_data,
    input  busy, done, pass, timeout, stray, err_cnt, word_cnt, first_err_idx, first_err_data
  );
  modport slave (
    input  init_end, start, rd_en, rd_data,
    output busy, done, pass, timeout, stray, err_cnt, word_cnt, first_err_idx, first_err_data
  );
endinterface

// File: rtl/rd_data_checker.sv
// rd_data_checker: regenerates the SEED+k write pattern and checks each read word against it
module rd_data_checker #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_SIZE   = 1024,
  parameter logic [DATA_WIDTH-1:0] SEED       = '0,
  parameter int                    TIMEOUT    = 65535,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rd_data_checker_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, ARMED, CHECK, DONE} state_t;
  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] exp_word;
  logic [23:0]           wd;
  logic                  busy, done_q, pass_q, timeout_q, stray_q;
  logic [CNT_WIDTH-1:0]  err_cnt, word_cnt, first_err_idx;
  logic [DATA_WIDTH-1:0] first_err_data;
  logic                  live, arm, accept, mismatch, last, expire, idle_chk;
  assign live     = state == ARMED || state == CHECK;
  assign arm      = (state == IDLE || state == DONE) && bus.start && bus.init_end;
  assign accept   = live && bus.init_end && bus.rd_en;
  assign mismatch = bus.rd_data != exp_word;
  assign last     = accept && word_cnt == CNT_WIDTH'(MEM_SIZE - 1);
  assign idle_chk = state == CHECK && !bus.rd_en;
  // the watchdog only fires on a quiet cycle, so a word arriving on the expiry cycle wins
  assign expire   = idle_chk && bus.init_end && wd == 24'(TIMEOUT);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  // next-state logic; losing init_end aborts a run before anything else is considered
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = arm ? ARMED : IDLE;
      ARMED:   state_nxt = !bus.init_end ? IDLE : last ? DONE : bus.rd_en ? CHECK : ARMED;
      CHECK:   state_nxt = !bus.init_end ? IDLE : (last || expire) ? DONE : CHECK;
      default: state_nxt = arm ? ARMED : DONE;
    endcase
  end
  // state-decoded outputs
  always_comb busy = live;
  // comparison datapath, counters, sticky flags and watchdog
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      exp_word       <= SEED;
      wd             <= '0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
      stray_q        <= 1'b0;
      err_cnt        <= '0;
      word_cnt       <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else if (arm) begin
      exp_word       <= SEED;
      wd             <= '0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
      stray_q        <= 1'b0;
      err_cnt        <= '0;
      word_cnt       <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else begin
      wd <= idle_chk ? wd + 24'(wd != 24'(TIMEOUT)) : '0;
      if (bus.rd_en && !live) stray_q <= 1'b1;
      if (accept) begin
        exp_word <= exp_word + DATA_WIDTH'(1);
        word_cnt <= word_cnt + CNT_WIDTH'(1);
        if (mismatch && err_cnt != '1) err_cnt <= err_cnt + CNT_WIDTH'(1);
        if (mismatch && err_cnt == '0) begin
          first_err_idx  <= word_cnt;
          first_err_data <= bus.rd_data;
        end
      end
      if (last) begin
        done_q <= 1'b1;
        pass_q <= !mismatch && err_cnt == '0 && !timeout_q;
      end
      if (expire) begin
        done_q    <= 1'b1;
        pass_q    <= 1'b0;
        timeout_q <= 1'b1;
      end
    end
  assign bus.busy           = busy;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.timeout        = timeout_q;
  assign bus.stray          = stray_q;
  assign bus.err_cnt        = err_cnt;
  assign bus.word_cnt       = word_cnt;
  assign bus.first_err_idx  = first_err_idx;
  assign bus.first_err_data = first_err_data;
endmodule

// File: doc/rd_data_checker.md
Name: rd_data_checker

Overview:
- Sits downstream of master's user read port (usr_rd_en / usr_rd_data) and alongside generate_data.
- Regenerates the write pattern locally and compares each read word against it.
- Reports pass/fail, error count, first-error location and a watchdog timeout, giving the DDR2 bench and board builds a self-checking end-of-test verdict.

Parameters:
- DATA_WIDTH, 32, width of rd_data and pattern words
- MEM_SIZE, 1024, number of words expected per check run
- SEED, 0, value of pattern word 0; word k = SEED + k mod 2^DATA_WIDTH
- TIMEOUT, 65535, idle cycles between accepted words in CHECK before abort (max 2^24-1)
- CNT_WIDTH, 16, width of word and error counters; MEM_SIZE must be ≤ 2^CNT_WIDTH-1

Ports:
- clk  in  1  system clock, same domain as master user interface
- rst_n  in  1  asynchronous active-low reset
- init_end  in  1  DDR2 initialisation complete; level
- start  in  1  single-cycle arm pulse
- rd_en  in  1  read word valid this cycle
- rd_data  in  DATA_WIDTH  read word
- busy  out  1  high in ARMED/CHECK
- done  out  1  run finished (sticky until next start)
- pass  out  1  valid when done; 1 = all words matched, no timeout
- timeout  out  1  sticky; watchdog expired in current run
- stray  out  1  sticky; rd_en seen while IDLE or DONE
- err_cnt  out  CNT_WIDTH  mismatching words, saturating at all-ones
- word_cnt  out  CNT_WIDTH  words accepted in current run
- first_err_idx  out  CNT_WIDTH  index k of first mismatch
- first_err_data  out  DATA_WIDTH  rd_data of first mismatch

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; exp = SEED; watchdog = 0.
- States: IDLE, ARMED, CHECK, DONE.
- Transitions:
  - IDLE→ARMED on start && init_end.
  - start while init_end=0 is ignored.
  - ARMED→CHECK on first rd_en; that word is compared in the same cycle.
  - CHECK→DONE when the accepted word brings word_cnt to MEM_SIZE.
  - CHECK→DONE when the watchdog reaches TIMEOUT; sets timeout=1.
  - DONE→ARMED on start && init_end.
- Arming action (entry to ARMED):
  - clears err_cnt, word_cnt, first_err_*, timeout, stray, done, pass
  - exp = SEED
- Comparison:
  - Every rd_en cycle in ARMED/CHECK compares rd_data with exp.
  - exp increments by 1 after each accepted word, wrapping mod 2^DATA_WIDTH.
  - word_cnt increments by 1 per accepted word.
  - On mismatch, err_cnt increments, saturating at 2^CNT_WIDTH-1.
  - On the first mismatch of a run, latch first_err_idx = word_cnt (pre-increment) and first_err_data = rd_data.
- Latency: all outputs are registered; counters and flags reflect a word one cycle after its rd_en.
- done asserts the cycle after the MEM_SIZE-th word, or the cycle after watchdog expiry.
- pass = (err_cnt==0 && !timeout), computed including the final word; pass is 0 whenever done=0.
- Watchdog:
  - Counts cycles in CHECK with rd_en=0 and clears on every rd_en.
  - Inactive in ARMED, so an unbounded wait for the first word is allowed.
- busy = 1 in ARMED/CHECK.
- rd_en in IDLE/DONE: sets stray; no counter changes.
- start in ARMED/CHECK: ignored; no restart mid-run.
- init_end falling in ARMED/CHECK: abort to IDLE with busy=0, done=0, pass=0; counters hold their values for debug.
- rd_en and the watchdog-expiry cycle coinciding: the word is accepted, the watchdog clears, and no timeout is raised.
- Asynchronous reset mid-run: immediate return to reset values.

Test Plan:
- Clean run: init_end=1, start, 1024 words 0..1023 with random rd_en gaps <100 cycles → done=1, pass=1, err_cnt=0, word_cnt=1024, timeout=0, stray=0.
- Corruption: same run with words 5 and 700 XOR 0x1 → err_cnt=2, first_err_idx=5, first_err_data=0x00000004, pass=0.
- Timeout: TIMEOUT=100; send 10 good words then stop → done=1 exactly 101 cycles after the 10th rd_en; timeout=1, pass=0, word_cnt=10.
- Wrap: SEED=0xFFFFFFFE, MEM_SIZE=4, data FFFFFFFE, FFFFFFFF, 0, 1 → pass=1.
- Stray/re-arm: rd_en in IDLE → stray=1. Then start with init_end=1 → stray=0, busy=1. Mid-run init_end=0 → busy=0, done=0.
- Saturation: CNT_WIDTH=4, MEM_SIZE=15, all 15 words wrong → err_cnt=15; a second run with all-correct data → err_cnt=0, pass=1.
